// File: rtl/sc_control.sv
// -----------------------------------------------------------------------------
// sc_control
//
// Main control decoder for the single-cycle LEGv8-subset datapath. The 11-bit
// opcode field (instruction bits [31:21]) is decoded combinationally into the
// datapath control signals. A single sticky status bit records that an
// undefined opcode was seen on a clock edge, for debug visibility.
//
// Ports
//   clk          in   1   system clock (status register only)
//   rst          in   1   synchronous active-high reset (status register only)
//   opcode       in  11   instruction bits [31:21]
//   Reg2Loc      out  1   1: read port 2 uses Rt [4:0]; 0: uses Rm
//   ALUSrc       out  1   1: ALU operand B is the extended immediate
//   MemtoReg     out  1   1: write-back from data-memory read data
//   RegWrite     out  1   register-file write enable
//   MemRead      out  1   data-memory read enable
//   MemWrite     out  1   data-memory write enable
//   Branch       out  1   conditional branch (CBZ)
//   Uncondbranch out  1   unconditional branch (B)
//   ALUOp        out  4   0000 AND, 0001 ORR, 0010 ADD, 0110 SUB, 0111 pass-B
//   SignOp       out  2   immediate format: 00 I/none, 01 D, 10 CB, 11 B
//   IllegalOp    out  1   sticky: an undefined opcode was sampled on an edge
// -----------------------------------------------------------------------------
module sc_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] opcode,
    output logic        Reg2Loc,
    output logic        ALUSrc,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        Branch,
    output logic        Uncondbranch,
    output logic [3:0]  ALUOp,
    output logic [1:0]  SignOp,
    output logic        IllegalOp
);

    // Flags ordered Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
    // Branch, Uncondbranch; followed by ALUOp and SignOp.
    logic [13:0] ctrl;
    logic        no_match;

    // The patterns are disjoint, so case order carries no priority. With
    // case inside, '?' in an item is a wildcard, while X/Z bits on the opcode
    // itself never match anything and fall through to the NOP default.
    always_comb begin
        ctrl     = '0;
        no_match = 1'b0;
        case (opcode) inside
            11'b10001010000: ctrl = {8'b0001_0000, 4'b0000, 2'b00}; // AND
            11'b10101010000: ctrl = {8'b0001_0000, 4'b0001, 2'b00}; // ORR
            11'b10001011000: ctrl = {8'b0001_0000, 4'b0010, 2'b00}; // ADD
            11'b11001011000: ctrl = {8'b0001_0000, 4'b0110, 2'b00}; // SUB
            11'b1001000100?: ctrl = {8'b0101_0000, 4'b0010, 2'b00}; // ADDI
            11'b1101000100?: ctrl = {8'b0101_0000, 4'b0110, 2'b00}; // SUBI
            11'b110100101??: ctrl = {8'b0101_0000, 4'b0111, 2'b00}; // MOVZ
            11'b000101?????: ctrl = {8'b0000_0001, 4'b0000, 2'b11}; // B
            11'b10110100???: ctrl = {8'b1000_0010, 4'b0111, 2'b10}; // CBZ
            11'b11111000010: ctrl = {8'b0111_1000, 4'b0010, 2'b01}; // LDUR
            11'b11111000000: ctrl = {8'b1100_0100, 4'b0010, 2'b01}; // STUR
            default: begin
                ctrl     = '0;
                no_match = 1'b1;
            end
        endcase
    end

    assign {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
            Branch, Uncondbranch, ALUOp, SignOp} = ctrl;

    // Sticky debug flag; reset on the same edge beats an illegal opcode.
    always_ff @(posedge clk) begin
        if (rst) begin
            IllegalOp <= 1'b0;
        end else if (no_match) begin
            IllegalOp <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sc_control.sv
module tb_sc_control;

    logic        clk;
    logic        rst;
    logic [10:0] opcode;
    logic        Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite;
    logic        Branch, Uncondbranch, IllegalOp;
    logic [3:0]  ALUOp;
    logic [1:0]  SignOp;
    logic [13:0] dut_vec;

    int checks = 0;
    int errors = 0;

    sc_control dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .Reg2Loc      (Reg2Loc),
        .ALUSrc       (ALUSrc),
        .MemtoReg     (MemtoReg),
        .RegWrite     (RegWrite),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .Branch       (Branch),
        .Uncondbranch (Uncondbranch),
        .ALUOp        (ALUOp),
        .SignOp       (SignOp),
        .IllegalOp    (IllegalOp)
    );

    assign dut_vec = {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
                      Branch, Uncondbranch, ALUOp, SignOp};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference table: an opcode matches an entry when its bits under the
    // mask equal the entry value. Output vector order matches dut_vec.
    logic [10:0] ref_mask [11] = '{11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FE,
                                   11'h7FE, 11'h7FC, 11'h7E0, 11'h7F8, 11'h7FF,
                                   11'h7FF};
    logic [10:0] ref_val  [11] = '{11'b10001010000, 11'b10101010000,
                                   11'b10001011000, 11'b11001011000,
                                   11'b10010001000, 11'b11010001000,
                                   11'b11010010100, 11'b00010100000,
                                   11'b10110100000, 11'b11111000010,
                                   11'b11111000000};
    logic [13:0] ref_out  [11] = '{14'b00010000_0000_00, 14'b00010000_0001_00,
                                   14'b00010000_0010_00, 14'b00010000_0110_00,
                                   14'b01010000_0010_00, 14'b01010000_0110_00,
                                   14'b01010000_0111_00, 14'b00000001_0000_11,
                                   14'b10000010_0111_10, 14'b01111000_0010_01,
                                   14'b11000100_0010_01};

    function automatic bit ref_legal(input logic [10:0] op);
        for (int i = 0; i < 11; i++)
            if ((op & ref_mask[i]) == ref_val[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [13:0] ref_decode(input logic [10:0] op);
        for (int i = 0; i < 11; i++)
            if ((op & ref_mask[i]) == ref_val[i]) return ref_out[i];
        return 14'd0;
    endfunction

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (opcode %b)", tag, got, exp, opcode);
        end
    endtask

    // Drive an opcode away from the rising edge and sample the decode 1 ns later.
    task automatic apply_and_check(input string tag, input logic [10:0] op,
                                   input logic [13:0] exp);
        @(negedge clk);
        opcode = op;
        #1;
        check(tag, {2'b00, dut_vec}, {2'b00, exp});
    endtask

    logic [10:0] op_r;
    bit          model_flag;
    int          n_undef;

    initial begin
        rst    = 1'b1;
        opcode = 11'b10001011000;
        @(posedge clk);
        #1;
        check("reset_flag", {15'd0, IllegalOp}, 16'd0);

        // R-type
        apply_and_check("AND", 11'b10001010000, 14'b00010000_0000_00);
        apply_and_check("ORR", 11'b10101010000, 14'b00010000_0001_00);
        apply_and_check("ADD", 11'b10001011000, 14'b00010000_0010_00);
        apply_and_check("SUB", 11'b11001011000, 14'b00010000_0110_00);

        // Immediates, including the don't-care low bits
        for (int b = 0; b < 2; b++) begin
            apply_and_check("ADDI", {10'b1001000100, b[0]}, 14'b01010000_0010_00);
            apply_and_check("SUBI", {10'b1101000100, b[0]}, 14'b01010000_0110_00);
        end
        for (int b = 0; b < 4; b++)
            apply_and_check("MOVZ", {9'b110100101, b[1:0]}, 14'b01010000_0111_00);

        // Branches
        for (int b = 0; b < 32; b++)
            apply_and_check("B", {6'b000101, b[4:0]}, 14'b00000001_0000_11);
        for (int b = 0; b < 8; b++)
            apply_and_check("CBZ", {8'b10110100, b[2:0]}, 14'b10000010_0111_10);

        // Memory
        apply_and_check("LDUR", 11'b11111000010, 14'b01111000_0010_01);
        apply_and_check("STUR", 11'b11111000000, 14'b11000100_0010_01);

        // Undefined opcodes
        apply_and_check("undef_zero", 11'h000, 14'd0);
        apply_and_check("undef_ones", 11'h7FF, 14'd0);
        n_undef = 0;
        while (n_undef < 12) begin
            op_r = 11'($urandom);
            if (!ref_legal(op_r)) begin
                apply_and_check("undef_rand", op_r, 14'd0);
                n_undef++;
            end
        end

        // Reset held throughout so far: flag must still be clear
        check("flag_under_rst", {15'd0, IllegalOp}, 16'd0);

        // Directed status-flag sequence
        @(negedge clk); rst = 1'b1; opcode = 11'b10001011000;
        @(posedge clk); #1;
        check("flag_rst", {15'd0, IllegalOp}, 16'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("flag_add", {15'd0, IllegalOp}, 16'd0);
        @(negedge clk); opcode = 11'h7FF;
        @(posedge clk); #1;
        check("flag_set", {15'd0, IllegalOp}, 16'd1);
        @(negedge clk); opcode = 11'b10001011000;
        @(posedge clk); #1;
        check("flag_sticky", {15'd0, IllegalOp}, 16'd1);
        @(negedge clk); rst = 1'b1; opcode = 11'h7FF;
        #1;
        check("decode_in_rst", {2'b00, dut_vec}, 16'd0);
        @(posedge clk); #1;
        check("flag_rst_wins", {15'd0, IllegalOp}, 16'd0);

        // Random mix: decode vs table model, sticky flag vs behavioural model,
        // with occasional resets that must not disturb decode.
        model_flag = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0: op_r = 11'($urandom);
                1: op_r = ref_val[$urandom_range(0, 10)] | (11'($urandom) & ~ref_mask[$urandom_range(0, 10)]);
                default: op_r = ref_val[$urandom_range(0, 10)];
            endcase
            opcode = op_r;
            #1;
            check("rand_decode", {2'b00, dut_vec}, {2'b00, ref_decode(op_r)});
            if (rst) model_flag = 1'b0;
            else if (!ref_legal(op_r)) model_flag = 1'b1;
            @(posedge clk); #1;
            check("rand_flag", {15'd0, IllegalOp}, {15'd0, model_flag});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
